// File: rtl/firebird7_in_gate1_tessent_tdr_sel_w3_pkg.sv
// ============================================================================
// Module  : firebird7_in_gate1_tessent_tdr_pkg
// Brief   : Shared types and helpers for the gate1 select/data IJTAG TDR.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package firebird7_in_gate1_tessent_tdr_pkg;

  localparam int unsigned TDR_DATA_W = 3;

  typedef struct packed {
    logic                  sel;
    logic [TDR_DATA_W-1:0] data;
  } tdr_word_t;

  // Bit that, appended to the word, makes the total count of ones even.
  function automatic logic even_parity(input tdr_word_t word);
    return ^word;
  endfunction

endpackage

`default_nettype wire

// File: rtl/firebird7_in_gate1_tessent_tdr_sel_w3_if.sv
// ============================================================================
// Module  : firebird7_in_gate1_tessent_tdr_sel_w3_if
// Brief   : IJTAG segment controls plus mux-facing outputs of the gate1 TDR.
//           parity_error exists only when FIREBIRD7_TDR_PARITY_EN is defined.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface firebird7_in_gate1_tessent_tdr_sel_w3_if #(
  parameter int unsigned DATA_WIDTH = 3
);

  logic                  ijtag_sel;
  logic                  ijtag_ce;
  logic                  ijtag_se;
  logic                  ijtag_ue;
  logic                  ijtag_si;
  logic                  ijtag_so;
  logic [DATA_WIDTH-1:0] functional_data_in;
  logic                  ijtag_select;
  logic [DATA_WIDTH-1:0] ijtag_data_out;
`ifdef FIREBIRD7_TDR_PARITY_EN
  logic                  parity_error;
`endif

  modport master (
    output ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, functional_data_in,
    input  ijtag_so, ijtag_select, ijtag_data_out
`ifdef FIREBIRD7_TDR_PARITY_EN
    , input parity_error
`endif
  );

  modport slave (
    input  ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, functional_data_in,
    output ijtag_so, ijtag_select, ijtag_data_out
`ifdef FIREBIRD7_TDR_PARITY_EN
    , output parity_error
`endif
  );

endinterface

`default_nettype wire

// File: rtl/firebird7_in_gate1_tessent_tdr_sel_w3.sv
// ============================================================================
// Module  : firebird7_in_gate1_tessent_tdr_sel_w3
// Brief   : Leaf IJTAG TDR driving the gate1 mux select/data; optional chain
//           parity guard via macro FIREBIRD7_TDR_PARITY_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module firebird7_in_gate1_tessent_tdr_sel_w3
  import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = TDR_DATA_W,
  parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                                   ijtag_tck,
  input  logic                                   ijtag_reset,
  firebird7_in_gate1_tessent_tdr_sel_w3_if.slave tdr
);

`ifdef FIREBIRD7_TDR_PARITY_EN
  localparam int unsigned c_chain_len = DATA_WIDTH + 2;
`else
  localparam int unsigned c_chain_len = DATA_WIDTH + 1;
`endif

  logic [c_chain_len-1:0] r_shift;
  tdr_word_t              r_upd;
  tdr_word_t              w_cap_word;
  logic [c_chain_len-1:0] w_capture;

  // Capture reflects the live shadow select, not what is sitting in the chain.
  assign w_cap_word.sel  = r_upd.sel;
  assign w_cap_word.data = tdr.functional_data_in;

`ifdef FIREBIRD7_TDR_PARITY_EN
  logic r_parity_error;
  assign w_capture = {even_parity(w_cap_word), w_cap_word};
`else
  assign w_capture = w_cap_word;
`endif

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      r_shift <= '0;
    end else if (tdr.ijtag_sel) begin
      if (tdr.ijtag_ce) begin
        r_shift <= w_capture;
      end else if (tdr.ijtag_se) begin
        r_shift <= {tdr.ijtag_si, r_shift[c_chain_len-1:1]};
      end
    end
  end

  // Shadow stage on the falling edge keeps the mux inputs stable while shifting.
  always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      r_upd.sel  <= 1'b0;
      r_upd.data <= RESET_DATA;
`ifdef FIREBIRD7_TDR_PARITY_EN
      r_parity_error <= 1'b0;
`endif
    end else if (tdr.ijtag_sel && tdr.ijtag_ue) begin
`ifdef FIREBIRD7_TDR_PARITY_EN
      if (^r_shift) begin
        r_parity_error <= 1'b1;
      end else begin
        r_upd <= tdr_word_t'(r_shift[DATA_WIDTH:0]);
      end
`else
      r_upd <= tdr_word_t'(r_shift[DATA_WIDTH:0]);
`endif
    end
  end

  assign tdr.ijtag_so       = r_shift[0];
  assign tdr.ijtag_select   = r_upd.sel;
  assign tdr.ijtag_data_out = r_upd.data;
`ifdef FIREBIRD7_TDR_PARITY_EN
  assign tdr.parity_error   = r_parity_error;
`endif

endmodule

`default_nettype wire

// File: tb/tb_firebird7_in_gate1_tessent_tdr_sel_w3.sv
// ============================================================================
// Module  : tb_firebird7_in_gate1_tessent_tdr_sel_w3
// Brief   : Self-checking bench for the gate1 select/data TDR (table, directed,
//           random vs queue-based model). Honours FIREBIRD7_TDR_PARITY_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_firebird7_in_gate1_tessent_tdr_sel_w3;

  localparam int DW = 3;
`ifdef FIREBIRD7_TDR_PARITY_EN
  localparam int L      = DW + 2;
  localparam bit PARITY = 1'b1;
`else
  localparam int L      = DW + 1;
  localparam bit PARITY = 1'b0;
`endif

  logic ijtag_tck   = 1'b0;
  logic ijtag_reset = 1'b0;
  always #5 ijtag_tck = ~ijtag_tck;

  firebird7_in_gate1_tessent_tdr_sel_w3_if #(.DATA_WIDTH(DW)) bus();

  firebird7_in_gate1_tessent_tdr_sel_w3 #(
    .DATA_WIDTH (DW),
    .RESET_DATA (3'b000)
  ) dut (
    .ijtag_tck   (ijtag_tck),
    .ijtag_reset (ijtag_reset),
    .tdr         (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: chain as a queue, index 0 is the scan-out end.
  bit          m_chain[$];
  bit          m_sel;
  bit [DW-1:0] m_data;
  bit          m_perr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_chain.delete();
    repeat (L) m_chain.push_back(1'b0);
    m_sel  = 1'b0;
    m_data = '0;
    m_perr = 1'b0;
  endtask

  task automatic model_step(input logic s, ce, se, ue, si, input logic [DW-1:0] fdi);
    int          ones;
    bit [DW-1:0] w;
    if (s && ue) begin
      ones = 0;
      foreach (m_chain[i]) ones += int'(m_chain[i]);
      if (PARITY && (ones % 2 == 1)) begin
        m_perr = 1'b1;
      end else begin
        for (int i = 0; i < DW; i++) w[i] = m_chain[i];
        m_sel  = m_chain[DW];
        m_data = w;
      end
    end
    if (s) begin
      if (ce) begin
        m_chain.delete();
        for (int i = 0; i < DW; i++) m_chain.push_back(fdi[i]);
        m_chain.push_back(m_sel);
        if (PARITY) m_chain.push_back(bit'(($countones(fdi) + int'(m_sel)) % 2));
      end else if (se) begin
        void'(m_chain.pop_front());
        m_chain.push_back(si);
      end
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, "_so"},     32'(bus.ijtag_so),       32'(m_chain[0]));
    chk({tag, "_select"}, 32'(bus.ijtag_select),   32'(m_sel));
    chk({tag, "_data"},   32'(bus.ijtag_data_out), 32'(m_data));
`ifdef FIREBIRD7_TDR_PARITY_EN
    chk({tag, "_perr"},   32'(bus.parity_error),   32'(m_perr));
`endif
  endtask

  // Called at posedge+1; inputs hold through the next negedge and posedge.
  task automatic cycle(input logic s, ce, se, ue, si, input logic [DW-1:0] fdi, input string tag);
    bus.ijtag_sel = s;
    bus.ijtag_ce  = ce;
    bus.ijtag_se  = se;
    bus.ijtag_ue  = ue;
    bus.ijtag_si  = si;
    bus.functional_data_in = fdi;
    model_step(s, ce, se, ue, si, fdi);
    @(posedge ijtag_tck);
    #1;
    compare_model(tag);
  endtask

  function automatic logic [4:0] mk_word(input logic s, input logic [DW-1:0] d, input bit good);
    logic [4:0] w;
    w = {1'b0, s, d};
    if (PARITY) w[4] = (^{s, d}) ^ !good;
    return w;
  endfunction

  task automatic shift_word(input logic [4:0] w, input string tag);
    for (int i = 0; i < L; i++) cycle(1, 0, 1, 0, w[i], '0, tag);
  endtask

  typedef struct {
    logic          s, ce, se, ue, si;
    logic [DW-1:0] fdi;
    logic          e_so, e_sel;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t tbl[13];

  logic [4:0] w1, w2;

  initial begin
    tbl[0]  = '{1, 0, 1, 0, 1, 3'b000, 0, 0, 3'b000};
    tbl[1]  = '{1, 0, 1, 0, 0, 3'b000, 0, 0, 3'b000};
    tbl[2]  = '{1, 0, 1, 0, 1, 3'b000, 0, 0, 3'b000};
    tbl[3]  = '{1, 0, 1, 0, 1, 3'b000, 1, 0, 3'b000};
    tbl[4]  = '{1, 0, 0, 1, 0, 3'b000, 1, 1, 3'b101};
    tbl[5]  = '{1, 1, 0, 0, 0, 3'b110, 0, 1, 3'b101};
    tbl[6]  = '{1, 0, 1, 0, 0, 3'b000, 1, 1, 3'b101};
    tbl[7]  = '{1, 0, 1, 0, 0, 3'b000, 1, 1, 3'b101};
    tbl[8]  = '{1, 0, 1, 0, 0, 3'b000, 1, 1, 3'b101};
    tbl[9]  = '{1, 0, 1, 0, 0, 3'b000, 0, 1, 3'b101};
    tbl[10] = '{1, 1, 1, 0, 0, 3'b011, 1, 1, 3'b101};
    tbl[11] = '{0, 0, 1, 1, 0, 3'b000, 1, 1, 3'b101};
    tbl[12] = '{0, 1, 0, 1, 0, 3'b000, 1, 1, 3'b101};

    bus.ijtag_sel = 0; bus.ijtag_ce = 0; bus.ijtag_se = 0;
    bus.ijtag_ue  = 0; bus.ijtag_si = 0; bus.functional_data_in = '0;
    model_reset();
    #1;
    compare_model("reset");
    @(posedge ijtag_tck); #1;
    ijtag_reset = 1'b1;

`ifndef FIREBIRD7_TDR_PARITY_EN
    // Load 1,0,1,1 / capture 110 / priority / deselect
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].s, tbl[i].ce, tbl[i].se, tbl[i].ue, tbl[i].si, tbl[i].fdi, $sformatf("tblm%0d", i));
      chk($sformatf("tbl%0d_so", i),     32'(bus.ijtag_so),       32'(tbl[i].e_so));
      chk($sformatf("tbl%0d_select", i), 32'(bus.ijtag_select),   32'(tbl[i].e_sel));
      chk($sformatf("tbl%0d_data", i),   32'(bus.ijtag_data_out), 32'(tbl[i].e_data));
    end
`endif

    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 1'($urandom),
            $urandom_range(0, 3) == 0, 1'($urandom), 3'($urandom), "rand");
    end

    // Asynchronous reset in the middle of a shift, away from any clock edge
    shift_word(mk_word(1, 3'b111, 1), "pre_rst");
    cycle(1, 0, 0, 1, 0, '0, "pre_rst_upd");
    cycle(1, 0, 1, 0, 1, '0, "pre_rst_shift");
    #2;
    ijtag_reset = 1'b0;
    #1;
    chk("async_rst_so",     32'(bus.ijtag_so),       32'd0);
    chk("async_rst_select", 32'(bus.ijtag_select),   32'd0);
    chk("async_rst_data",   32'(bus.ijtag_data_out), 32'd0);
    model_reset();
    @(posedge ijtag_tck); #1;
    ijtag_reset = 1'b1;

    // Back-to-back loads; second word starts shifting on the update cycle
    w1 = mk_word(1, 3'b011, 1);
    w2 = mk_word(0, 3'b100, 1);
    shift_word(w1, "b2b_w1");
    chk("b2b_pre_data", 32'(bus.ijtag_data_out), 32'h0);
    cycle(1, 0, 1, 1, w2[0], '0, "b2b_upd1");
    chk("b2b_upd1_select", 32'(bus.ijtag_select),   32'h1);
    chk("b2b_upd1_data",   32'(bus.ijtag_data_out), 32'h3);
    for (int i = 1; i < L; i++) cycle(1, 0, 1, 0, w2[i], '0, "b2b_w2");
    chk("b2b_hold_data", 32'(bus.ijtag_data_out), 32'h3);
    cycle(1, 0, 0, 1, 0, '0, "b2b_upd2");
    chk("b2b_upd2_select", 32'(bus.ijtag_select),   32'h0);
    chk("b2b_upd2_data",   32'(bus.ijtag_data_out), 32'h4);

`ifdef FIREBIRD7_TDR_PARITY_EN
    shift_word(5'b0_1_101, "par_bad");
    cycle(1, 0, 0, 1, 0, '0, "par_bad_upd");
    chk("par_bad_perr",   32'(bus.parity_error),   32'h1);
    chk("par_bad_select", 32'(bus.ijtag_select),   32'h0);
    chk("par_bad_data",   32'(bus.ijtag_data_out), 32'h4);
    shift_word(5'b1_1_101, "par_good");
    cycle(1, 0, 0, 1, 0, '0, "par_good_upd");
    chk("par_good_perr",   32'(bus.parity_error),   32'h1);
    chk("par_good_select", 32'(bus.ijtag_select),   32'h1);
    chk("par_good_data",   32'(bus.ijtag_data_out), 32'h5);
    ijtag_reset = 1'b0;
    #1;
    chk("par_rst_perr", 32'(bus.parity_error), 32'h0);
    model_reset();
    @(posedge ijtag_tck); #1;
    ijtag_reset = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
